// File: rtl/axi_channel_buffer_if.sv
// AXI4 five-channel bundle; the buffer takes the slave view upstream and
// the master view downstream.
interface axi_channel_buffer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 2
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic                  aw_lock;
  logic [3:0]            aw_cache;
  logic [2:0]            aw_prot;
  logic [3:0]            aw_qos;
  logic [3:0]            aw_region;
  logic                  aw_valid;
  logic                  aw_ready;

  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_last;
  logic                  w_valid;
  logic                  w_ready;

  logic [ID_WIDTH-1:0]   b_id;
  logic [1:0]            b_resp;
  logic                  b_valid;
  logic                  b_ready;

  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  ar_lock;
  logic [3:0]            ar_cache;
  logic [2:0]            ar_prot;
  logic [3:0]            ar_qos;
  logic [3:0]            ar_region;
  logic                  ar_valid;
  logic                  ar_ready;

  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_valid,
    output w_ready,
    output b_id, b_resp, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_channel_buffer.sv
// Single-clock AXI4 buffer: one FIFO per channel plus outstanding-transaction
// limiters on AW and AR.
module axi_channel_buffer #(
  parameter int unsigned DATA_WIDTH         = 32,
  parameter int unsigned ADDR_WIDTH         = 32,
  parameter int unsigned ID_WIDTH           = 2,
  parameter int unsigned FIFO_DEPTH         = 4,
  parameter int unsigned MAX_WR_OUTSTANDING = 8,
  parameter int unsigned MAX_RD_OUTSTANDING = 8
) (
  input  logic                                    axi_aclk,
  input  logic                                    axi_aresetn,
  axi_channel_buffer_if.slave                     s_axi,
  axi_channel_buffer_if.master                    m_axi,
  output logic [$clog2(MAX_WR_OUTSTANDING+1)-1:0] wr_outstanding_o,
  output logic [$clog2(MAX_RD_OUTSTANDING+1)-1:0] rd_outstanding_o
);
  localparam int unsigned WR_CNT_W = $clog2(MAX_WR_OUTSTANDING + 1);
  localparam int unsigned RD_CNT_W = $clog2(MAX_RD_OUTSTANDING + 1);
  localparam int unsigned AX_W     = ID_WIDTH + ADDR_WIDTH + 29;
  localparam int unsigned W_W      = DATA_WIDTH + DATA_WIDTH / 8 + 1;
  localparam int unsigned B_W      = ID_WIDTH + 2;
  localparam int unsigned R_W      = ID_WIDTH + DATA_WIDTH + 3;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("axi_channel_buffer: FIFO_DEPTH must be a power of two >= 2");
  end
  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("axi_channel_buffer: DATA_WIDTH must be a multiple of 8, minimum 8");
  end
  if (ID_WIDTH < 1 || MAX_WR_OUTSTANDING < 1 || MAX_RD_OUTSTANDING < 1) begin : g_bad_limits
    $error("axi_channel_buffer: ID_WIDTH and outstanding limits must be >= 1");
  end

  logic [WR_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [RD_CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic                wr_room, rd_room, aw_fifo_ready, ar_fifo_ready;
  logic                aw_hs, b_hs, ar_hs, r_last_hs;
  logic [AX_W-1:0]     aw_in, aw_out, ar_in, ar_out;
  logic [W_W-1:0]      w_in, w_out;
  logic [B_W-1:0]      b_in, b_out;
  logic [R_W-1:0]      r_in, r_out;

  assign wr_room        = wr_cnt_q < WR_CNT_W'(MAX_WR_OUTSTANDING);
  assign rd_room        = rd_cnt_q < RD_CNT_W'(MAX_RD_OUTSTANDING);
  assign s_axi.aw_ready = aw_fifo_ready & wr_room;
  assign s_axi.ar_ready = ar_fifo_ready & rd_room;

  assign aw_in = {s_axi.aw_id, s_axi.aw_addr, s_axi.aw_len, s_axi.aw_size, s_axi.aw_burst,
                  s_axi.aw_lock, s_axi.aw_cache, s_axi.aw_prot, s_axi.aw_qos, s_axi.aw_region};
  assign {m_axi.aw_id, m_axi.aw_addr, m_axi.aw_len, m_axi.aw_size, m_axi.aw_burst,
          m_axi.aw_lock, m_axi.aw_cache, m_axi.aw_prot, m_axi.aw_qos, m_axi.aw_region} = aw_out;
  assign ar_in = {s_axi.ar_id, s_axi.ar_addr, s_axi.ar_len, s_axi.ar_size, s_axi.ar_burst,
                  s_axi.ar_lock, s_axi.ar_cache, s_axi.ar_prot, s_axi.ar_qos, s_axi.ar_region};
  assign {m_axi.ar_id, m_axi.ar_addr, m_axi.ar_len, m_axi.ar_size, m_axi.ar_burst,
          m_axi.ar_lock, m_axi.ar_cache, m_axi.ar_prot, m_axi.ar_qos, m_axi.ar_region} = ar_out;
  assign w_in  = {s_axi.w_data, s_axi.w_strb, s_axi.w_last};
  assign {m_axi.w_data, m_axi.w_strb, m_axi.w_last} = w_out;
  assign b_in  = {m_axi.b_id, m_axi.b_resp};
  assign {s_axi.b_id, s_axi.b_resp} = b_out;
  assign r_in  = {m_axi.r_id, m_axi.r_data, m_axi.r_resp, m_axi.r_last};
  assign {s_axi.r_id, s_axi.r_data, s_axi.r_resp, s_axi.r_last} = r_out;

  // Address FIFOs see valid only when the limiter has room, so push == upstream handshake.
  axi_channel_buffer_fifo #(.WIDTH(AX_W), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
    .clk(axi_aclk), .rst_n(axi_aresetn),
    .in_valid_i(s_axi.aw_valid & wr_room), .in_ready_o(aw_fifo_ready), .in_data_i(aw_in),
    .out_valid_o(m_axi.aw_valid), .out_ready_i(m_axi.aw_ready), .out_data_o(aw_out));

  axi_channel_buffer_fifo #(.WIDTH(W_W), .DEPTH(FIFO_DEPTH)) u_w_fifo (
    .clk(axi_aclk), .rst_n(axi_aresetn),
    .in_valid_i(s_axi.w_valid), .in_ready_o(s_axi.w_ready), .in_data_i(w_in),
    .out_valid_o(m_axi.w_valid), .out_ready_i(m_axi.w_ready), .out_data_o(w_out));

  axi_channel_buffer_fifo #(.WIDTH(B_W), .DEPTH(FIFO_DEPTH)) u_b_fifo (
    .clk(axi_aclk), .rst_n(axi_aresetn),
    .in_valid_i(m_axi.b_valid), .in_ready_o(m_axi.b_ready), .in_data_i(b_in),
    .out_valid_o(s_axi.b_valid), .out_ready_i(s_axi.b_ready), .out_data_o(b_out));

  axi_channel_buffer_fifo #(.WIDTH(AX_W), .DEPTH(FIFO_DEPTH)) u_ar_fifo (
    .clk(axi_aclk), .rst_n(axi_aresetn),
    .in_valid_i(s_axi.ar_valid & rd_room), .in_ready_o(ar_fifo_ready), .in_data_i(ar_in),
    .out_valid_o(m_axi.ar_valid), .out_ready_i(m_axi.ar_ready), .out_data_o(ar_out));

  axi_channel_buffer_fifo #(.WIDTH(R_W), .DEPTH(FIFO_DEPTH)) u_r_fifo (
    .clk(axi_aclk), .rst_n(axi_aresetn),
    .in_valid_i(m_axi.r_valid), .in_ready_o(m_axi.r_ready), .in_data_i(r_in),
    .out_valid_o(s_axi.r_valid), .out_ready_i(s_axi.r_ready), .out_data_o(r_out));

  assign aw_hs     = s_axi.aw_valid & s_axi.aw_ready;
  assign b_hs      = s_axi.b_valid & s_axi.b_ready;
  assign ar_hs     = s_axi.ar_valid & s_axi.ar_ready;
  assign r_last_hs = s_axi.r_valid & s_axi.r_ready & s_axi.r_last;

  // Saturating up/down counters; coincident request and response cancel out.
  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (aw_hs && !b_hs && wr_room) begin
      wr_cnt_d = wr_cnt_q + WR_CNT_W'(1);
    end else if (!aw_hs && b_hs && wr_cnt_q != '0) begin
      wr_cnt_d = wr_cnt_q - WR_CNT_W'(1);
    end
    if (ar_hs && !r_last_hs && rd_room) begin
      rd_cnt_d = rd_cnt_q + RD_CNT_W'(1);
    end else if (!ar_hs && r_last_hs && rd_cnt_q != '0) begin
      rd_cnt_d = rd_cnt_q - RD_CNT_W'(1);
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign wr_outstanding_o = wr_cnt_q;
  assign rd_outstanding_o = rd_cnt_q;
endmodule

// Registered-storage FIFO, no bypass; ready is held low in reset and when full.
module axi_channel_buffer_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready_o  = rst_n & (cnt_q < CNT_W'(DEPTH));
  assign out_valid_o = (cnt_q != '0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!push && pop) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data_i;
    end
  end
endmodule

// File: doc/axi_channel_buffer.md
Name: axi_channel_buffer

Overview:
- Parametrised single-clock AXI4 buffer inserted between an AXI master and an AXI slave on the same clock domain.
- Supports any data, address and ID width, with no fixed list of supported widths.
- Each of the five channels (AW, W, B, AR, R) gets an independent FIFO of configurable depth.
- Separate limits cap the number of outstanding write and read transactions; current counts are exported for debug and performance monitoring.

Parameters:
- DATA_WIDTH, 32, AXI data width; any multiple of 8, minimum 8.
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 2, AXI ID width, minimum 1.
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, minimum 2.
- MAX_WR_OUTSTANDING, 8, maximum accepted-but-unresponded write transactions; minimum 1.
- MAX_RD_OUTSTANDING, 8, maximum accepted-but-unresponded read transactions; minimum 1.

Ports:
- axi_aclk  in  1  single clock for both sides.
- axi_aresetn  in  1  asynchronous active-low reset.
- s_axi_aw*  in/out  full AW bundle  slave-side write address (id, addr, len, size, burst, lock, cache, prot, qos, region, valid in; ready out).
- s_axi_w*  in/out  full W bundle  slave-side write data (data, strb DATA_WIDTH/8, last, valid in; ready out).
- s_axi_b*  out/in  full B bundle  slave-side write response (id, resp, valid out; ready in).
- s_axi_ar*  in/out  full AR bundle  slave-side read address.
- s_axi_r*  out/in  full R bundle  slave-side read data (id, data, resp, last, valid out; ready in).
- m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*  mirrored  master-side bundles, same widths.
- wr_outstanding_o  out  $clog2(MAX_WR_OUTSTANDING+1)  current outstanding write count.
- rd_outstanding_o  out  $clog2(MAX_RD_OUTSTANDING+1)  current outstanding read count.

Behaviour:
- Reset is asynchronous and active-low on axi_aresetn.
  - All FIFOs are emptied and both counters cleared to 0.
  - All valid outputs (m aw/w/ar, s b/r) are 0.
  - All ready outputs are forced to 0 while axi_aresetn is low.
  - Reset asserted mid-burst drops all in-flight beats; no recovery is attempted.
- Channel FIFO, identical for all five channels:
  - Push on input valid&&ready; pop on output valid&&ready.
  - Output valid = (count != 0); output payload is the head entry, registered, with no combinational input-to-output path.
  - Latency is 1 cycle: a beat pushed at edge N is visible on the output after edge N.
  - Input ready = (count < FIFO_DEPTH). When full, ready is 0 even if a pop occurs in the same cycle, so there is no ready/ready combinational path.
  - Push and pop in the same cycle: count unchanged, pointers both advance.
  - Empty with a same-cycle push: no bypass; valid rises the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - Payload order is strictly preserved; no field is modified.
- Write outstanding counter:
  - +1 on s_axi AW handshake; -1 on s_axi B handshake.
  - Simultaneous +1 and -1: unchanged.
  - s_axi_awready = aw_fifo_not_full && (wr_outstanding_o < MAX_WR_OUTSTANDING) && axi_aresetn.
  - W and B channels are not gated by the counter.
- Read outstanding counter:
  - +1 on s_axi AR handshake; -1 on s_axi R handshake with rlast = 1.
  - Simultaneous +1 and -1: unchanged.
  - s_axi_arready is gated identically, using MAX_RD_OUTSTANDING.
- Counters saturate and never wrap; underflow (B or final R with count 0) holds at 0.
- Unsupported parameters (FIFO_DEPTH not a power of two or < 2, DATA_WIDTH % 8 != 0) raise an elaboration-time $error.

Test Plan:
- Single write: one AW (addr 0x1000, len 0) plus one W (data 0xDEADBEEF, strb 0xF) -> both appear on m_axi one cycle after acceptance with identical fields; wr_outstanding_o = 1 until s_axi B handshake, then 0.
- FIFO full: FIFO_DEPTH=4, m_axi_wready = 0, push 4 W beats -> s_axi_wready drops after the 4th push. Raise m_axi_wready -> beats drain in order; s_axi_wready returns to 1 the cycle after the first pop.
- Outstanding limit: MAX_RD_OUTSTANDING=2, 3 back-to-back ARs, R withheld -> s_axi_arready = 0 after the 2nd. A 4-beat burst whose rlast completes re-enables arready the next cycle.
- Simultaneous events: AW handshake and B handshake in the same cycle with count 3 -> count stays 3. Push and pop on a half-full R FIFO -> count unchanged, data order intact.
- Width generality: DATA_WIDTH=128, ID_WIDTH=4, 8-beat write burst -> all 128-bit data and 16-bit strb transferred bit-exact, wlast on beat 8 only.
- Reset mid-operation: assert axi_aresetn low with 3 beats buffered and count 2 -> all valids and readies are 0 immediately (asynchronous). After release, counters read 0 and readies are 1 the first cycle.
